gcd_rr_scheduler: RTL and testbench

- Shares one GcdUnit between NUM_REQ independent requesters.
- Round-robin arbitration on the request side.
- In-order tag FIFO routes each 16-bit result back to the requester that issued the operands.
- Sits between client blocks and the GcdUnit instance; all interfaces are val/rdy, and a transfer fires when val && rdy.

---
 rtl/gcd_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_gcd_rr_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one GcdUnit between NUM_REQ val/rdy requesters.
// Optional per-requester response counters are enabled with GCD_SCHED_PERF_EN.
module gcd_rr_scheduler #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    cli_req_val,
  output logic [NUM_REQ-1:0]    cli_req_rdy,
  input  logic [NUM_REQ*32-1:0] cli_req_msg,
  output logic [NUM_REQ-1:0]    cli_resp_val,
  input  logic [NUM_REQ-1:0]    cli_resp_rdy,
  output logic [15:0]           cli_resp_msg,
  output logic                  gcd_req_val,
  input  logic                  gcd_req_rdy,
  output logic [31:0]           gcd_req_msg,
  input  logic                  gcd_resp_val,
  output logic                  gcd_resp_rdy,
  input  logic [15:0]           gcd_resp_msg,
  output logic                  proto_err
`ifdef GCD_SCHED_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [NUM_REQ*16-1:0] perf_cnt
`endif
);

  localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [TAG_W-1:0] ptr_q;
  logic [TAG_W-1:0] tag_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             proto_err_q;

  logic [TAG_W-1:0] grant, idx, head;
  logic             any_val, full, empty, issue_fire, resp_fire;

  function automatic logic [PTR_W-1:0] fifo_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);
  assign head  = tag_q[rd_ptr_q];

  // First valid requester at or after ptr_q, wrapping.
  always_comb begin
    grant   = '0;
    any_val = 1'b0;
    idx     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = TAG_W'((int'(ptr_q) + k) % int'(NUM_REQ));
      if (!any_val && cli_req_val[idx]) begin
        any_val = 1'b1;
        grant   = idx;
      end
    end
  end

  // Full blocks issue regardless of a same-cycle pop, so gcd_req_val never sees gcd_req_rdy.
  always_comb begin
    gcd_req_val = any_val && !full;
    gcd_req_msg = cli_req_msg[{grant, 5'b00000} +: 32];
    cli_req_rdy = '0;
    if (any_val && gcd_req_rdy && !full) cli_req_rdy[grant] = 1'b1;

    cli_resp_val = '0;
    if (!empty) cli_resp_val[head] = gcd_resp_val;
    gcd_resp_rdy = !empty && cli_resp_rdy[head];
    cli_resp_msg = gcd_resp_msg;
  end

  assign issue_fire = gcd_req_val && gcd_req_rdy;
  assign resp_fire  = gcd_resp_val && gcd_resp_rdy;
  assign proto_err  = proto_err_q;

  always_comb begin
    count_d = count_q;
    unique case ({issue_fire, resp_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) tag_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (issue_fire) begin
        tag_q[wr_ptr_q] <= grant;
        wr_ptr_q        <= fifo_inc(wr_ptr_q);
        ptr_q           <= (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
      if (resp_fire) rd_ptr_q <= fifo_inc(rd_ptr_q);
      if (gcd_resp_val && empty) proto_err_q <= 1'b1;
    end
  end

`ifdef GCD_SCHED_PERF_EN
  logic [15:0] perf_q [NUM_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REQ); i++) perf_q[i] <= '0;
    end else if (perf_clr) begin
      for (int i = 0; i < int'(NUM_REQ); i++) perf_q[i] <= '0;
    end else if (resp_fire && perf_q[head] != 16'hFFFF) begin
      perf_q[head] <= perf_q[head] + 16'd1;
    end
  end

  always_comb begin
    perf_cnt = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) perf_cnt[16*i +: 16] = perf_q[i];
  end
`endif

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed bench for gcd_rr_scheduler; the bench plays the GcdUnit and computes results itself.
module tb_gcd_rr_scheduler;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   cli_req_val, cli_req_rdy, cli_resp_val, cli_resp_rdy;
  logic [127:0] cli_req_msg;
  logic [15:0]  cli_resp_msg, gcd_resp_msg;
  logic         gcd_req_val, gcd_req_rdy, gcd_resp_val, gcd_resp_rdy, proto_err;
  logic [31:0]  gcd_req_msg;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] m [4];
  int g, prev;

  gcd_rr_scheduler #(.NUM_REQ(4), .MAX_OUTSTANDING(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cli_req_val  (cli_req_val),
    .cli_req_rdy  (cli_req_rdy),
    .cli_req_msg  (cli_req_msg),
    .cli_resp_val (cli_resp_val),
    .cli_resp_rdy (cli_resp_rdy),
    .cli_resp_msg (cli_resp_msg),
    .gcd_req_val  (gcd_req_val),
    .gcd_req_rdy  (gcd_req_rdy),
    .gcd_req_msg  (gcd_req_msg),
    .gcd_resp_val (gcd_resp_val),
    .gcd_resp_rdy (gcd_resp_rdy),
    .gcd_resp_msg (gcd_resp_msg),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sw_gcd(input logic [31:0] msg);
    logic [15:0] x, y, t;
    x = msg[15:0];
    y = msg[31:16];
    for (int i = 0; i < 64 && y != 0; i++) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m[0] = 32'h0012_0030;  // b=18,  a=48  -> 6
    m[1] = 32'h0015_000E;  // b=21,  a=14  -> 7
    m[2] = 32'h0023_0064;  // b=35,  a=100 -> 5
    m[3] = 32'h0011_0033;  // b=17,  a=51  -> 17
    cli_req_msg  = {m[3], m[2], m[1], m[0]};
    reset_n      = 1'b0;
    cli_req_val  = '0;
    cli_resp_rdy = '0;
    gcd_req_rdy  = 1'b0;
    gcd_resp_val = 1'b0;
    gcd_resp_msg = '0;

    // Reset state
    #2;
    check("rst_cli_req_rdy", 32'(cli_req_rdy), 0);
    check("rst_cli_resp_val", 32'(cli_resp_val), 0);
    check("rst_gcd_req_val", 32'(gcd_req_val), 0);
    check("rst_gcd_resp_rdy", 32'(gcd_resp_rdy), 0);
    check("rst_proto_err", 32'(proto_err), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single client 0
    cli_req_val  = 4'b0001;
    gcd_req_rdy  = 1'b1;
    cli_resp_rdy = 4'hF;
    #1;
    check("t1_req_val", 32'(gcd_req_val), 1);
    check("t1_req_msg", gcd_req_msg, 32'h0012_0030);
    check("t1_req_rdy", 32'(cli_req_rdy), 32'h1);
    tick();
    cli_req_val  = '0;
    gcd_resp_val = 1'b1;
    gcd_resp_msg = sw_gcd(m[0]);
    #1;
    check("t1_resp_val", 32'(cli_resp_val), 32'h1);
    check("t1_resp_msg", 32'(cli_resp_msg), 6);
    check("t1_resp_rdy", 32'(gcd_resp_rdy), 1);
    tick();
    gcd_resp_val = 1'b0;
    #1;
    check("t1_ptr", 32'(dut.ptr_q), 1);
    check("t1_proto_err", 32'(proto_err), 0);

    // All clients valid, GcdUnit always ready; one response per cycle trails each issue
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      g = (1 + k) % 4;
      cli_req_val  = 4'hF;
      gcd_resp_val = (k > 0);
      gcd_resp_msg = sw_gcd(m[prev]);
      #1;
      check("t2_grant", 32'(cli_req_rdy), 32'(1 << g));
      check("t2_req_msg", gcd_req_msg, m[g]);
      if (k > 0) begin
        check("t2_resp_route", 32'(cli_resp_val), 32'(1 << prev));
        check("t2_resp_msg", 32'(cli_resp_msg), 32'(sw_gcd(m[prev])));
      end
      tick();
      prev = g;
    end
    cli_req_val  = '0;
    gcd_resp_val = 1'b1;
    gcd_resp_msg = sw_gcd(m[prev]);
    #1;
    check("t2_last_route", 32'(cli_resp_val), 32'(1 << prev));
    tick();
    gcd_resp_val = 1'b0;
    #1;
    check("t2_ptr", 32'(dut.ptr_q), 1);
    check("t2_count", 32'(dut.count_q), 0);

    // Move ptr to 2, drain, then clients 1 and 3 contend
    cli_req_val = 4'b0010;
    tick();
    cli_req_val  = '0;
    gcd_resp_val = 1'b1;
    gcd_resp_msg = sw_gcd(m[1]);
    #1;
    check("t3_drain_route", 32'(cli_resp_val), 32'h2);
    tick();
    gcd_resp_val = 1'b0;
    cli_req_val  = 4'b1010;
    #1;
    check("t3_ptr_before", 32'(dut.ptr_q), 2);
    check("t3_first_grant", 32'(cli_req_rdy), 32'h8);
    tick();
    check("t3_second_grant", 32'(cli_req_rdy), 32'h2);
    tick();
    check("t3_ptr_end", 32'(dut.ptr_q), 2);

    // FIFO full: head tag 3 then 1; GcdUnit withholds responses
    cli_req_val = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_full_req_val", 32'(gcd_req_val), 0);
      check("t4_full_req_rdy", 32'(cli_req_rdy), 0);
      check("t4_full_count", 32'(dut.count_q), 2);
      tick();
    end
    gcd_resp_val = 1'b1;
    gcd_resp_msg = sw_gcd(m[3]);
    #1;
    check("t4_no_push_through", 32'(gcd_req_val), 0);
    check("t4_resp_route3", 32'(cli_resp_val), 32'h8);
    check("t4_resp_msg3", 32'(cli_resp_msg), 17);
    tick();
    gcd_resp_msg = sw_gcd(m[1]);
    #1;
    check("t4_issue_after_pop", 32'(cli_req_rdy), 32'h4);
    check("t4_resp_route1", 32'(cli_resp_val), 32'h2);
    tick();
    check("t4_count_pushpop", 32'(dut.count_q), 1);

    // Client 2 stalls its response for five cycles
    cli_req_val  = '0;
    cli_resp_rdy = 4'b1011;
    gcd_resp_msg = sw_gcd(m[2]);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5_stall_val", 32'(cli_resp_val), 32'h4);
      check("t5_stall_rdy", 32'(gcd_resp_rdy), 0);
      tick();
    end
    cli_resp_rdy = 4'hF;
    #1;
    check("t5_release_rdy", 32'(gcd_resp_rdy), 1);
    check("t5_release_msg", 32'(cli_resp_msg), 5);
    tick();
    gcd_resp_val = 1'b0;
    #1;
    check("t5_empty", 32'(dut.count_q), 0);

    // Response with empty FIFO
    gcd_resp_val = 1'b1;
    gcd_resp_msg = 16'h00AA;
    #1;
    check("t6_empty_rdy", 32'(gcd_resp_rdy), 0);
    check("t6_empty_val", 32'(cli_resp_val), 0);
    tick();
    gcd_resp_val = 1'b0;
    check("t6_proto_set", 32'(proto_err), 1);
    tick();
    tick();
    check("t6_proto_sticky", 32'(proto_err), 1);
    cli_req_val = 4'b0001;
    #1;
    check("t6_wrap_grant", 32'(cli_req_rdy), 32'h1);
    tick();
    cli_req_val = '0;
    check("t6_count_inflight", 32'(dut.count_q), 1);
    check("t6_ptr_inflight", 32'(dut.ptr_q), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_proto", 32'(proto_err), 0);
    check("t6_rst_count", 32'(dut.count_q), 0);
    check("t6_rst_ptr", 32'(dut.ptr_q), 0);
    check("t6_rst_req_val", 32'(gcd_req_val), 0);
    #3;
    reset_n = 1'b1;
    tick();
    check("t6_post_rst_proto", 32'(proto_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
